// File: rtl/wb_decoder_pkg.sv
// Shared types and helpers for the Wishbone slave-side address decoder.
// Holds the FSM state type, select-width helper and timeout counter width.
package wb_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam int TO_W = 16;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Combinational address window matcher with lowest-index priority.
// Reports whether any window hit and which one.
module wb_addr_match
    import wb_decoder_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 32,
    localparam int IW = sel_w(N)
) (
    input  logic [AW-1:0]   adr,
    input  logic [N*AW-1:0] base,
    input  logic [N*AW-1:0] mask,
    output logic            hit,
    output logic [IW-1:0]   idx
);

    // Scan downwards so the lowest matching window is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((adr & mask[i*AW +: AW]) == base[i*AW +: AW]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_decoder.sv
// Wishbone B4 classic single-master to multi-slave decoder and router.
// Optional stall timeout is built when WB_DECODER_TIMEOUT_EN is defined.
module wb_decoder
    import wb_decoder_pkg::*;
#(
    parameter int                     NUM_SLAVES = 4,
    parameter int                     AW         = 32,
    parameter int                     DW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_ADDR = '0,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = '0,
    parameter int                     TIMEOUT    = 255,
    localparam int                    SW         = sel_w(NUM_SLAVES)
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic [AW-1:0]            wbm_adr_i,
    input  logic [DW-1:0]            wbm_dat_i,
    input  logic [DW/8-1:0]          wbm_sel_i,
    input  logic                     wbm_we_i,
    input  logic                     wbm_cyc_i,
    input  logic                     wbm_stb_i,
    output logic [DW-1:0]            wbm_dat_o,
    output logic                     wbm_ack_o,
    output logic                     wbm_err_o,
    output logic [AW-1:0]            wbs_adr_o,
    output logic [DW-1:0]            wbs_dat_o,
    output logic [DW/8-1:0]          wbs_sel_o,
    output logic                     wbs_we_o,
    output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]    wbs_stb_o,
    input  logic [NUM_SLAVES*DW-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]    wbs_err_i,
    output logic                     active,
    output logic [SW-1:0]            slave_sel
);

    state_t state, state_n;
    logic [SW-1:0] sel_n;
    logic abort_pulse, abort_n;
    logic busy;
    logic hit;
    logic [SW-1:0] hit_idx;
    logic [NUM_SLAVES-1:0] sel_oh;
    logic [DW-1:0] s_dat;
    logic s_ack, s_err, s_resp;
    logic to_fire;

    wb_addr_match #(
        .N  (NUM_SLAVES),
        .AW (AW)
    ) u_match (
        .adr  (wbm_adr_i),
        .base (SLAVE_ADDR),
        .mask (SLAVE_MASK),
        .hit  (hit),
        .idx  (hit_idx)
    );

    assign busy = (state == ST_BUSY);

    always_comb begin
        sel_oh = '0;
        s_dat  = '0;
        s_ack  = 1'b0;
        s_err  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (busy && slave_sel == SW'(i)) begin
                sel_oh[i] = 1'b1;
                s_dat     = wbs_dat_i[i*DW +: DW];
                s_ack     = wbs_ack_i[i];
                s_err     = wbs_err_i[i];
            end
        end
    end

    assign s_resp = s_ack | s_err;

`ifdef WB_DECODER_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Counts only unanswered strobe cycles of the routed slave.
    always_ff @(posedge wb_clk) begin
        if (wb_rst || !busy || !wbm_stb_i || s_resp) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_fire = busy && wbm_cyc_i && wbm_stb_i && !s_resp
                     && (to_cnt == TO_W'(TIMEOUT));
`else
    logic unused_timeout;
    assign unused_timeout = |TO_W'(TIMEOUT);
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_n = state;
        sel_n   = slave_sel;
        abort_n = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (hit) begin
                        state_n = ST_BUSY;
                        sel_n   = hit_idx;
                    end else begin
                        state_n = ST_ABORT;
                        abort_n = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (!wbm_cyc_i) begin
                    state_n = ST_IDLE;
                end else if (to_fire) begin
                    state_n = ST_ABORT;
                    abort_n = 1'b1;
                end
            end
            ST_ABORT: begin
                if (!wbm_cyc_i) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state       <= ST_IDLE;
            slave_sel   <= '0;
            abort_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            slave_sel   <= sel_n;
            abort_pulse <= abort_n;
        end
    end

    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_sel_o = wbm_sel_i;
    assign wbs_we_o  = wbm_we_i;

    assign wbs_cyc_o = sel_oh & {NUM_SLAVES{wbm_cyc_i}};
    assign wbs_stb_o = sel_oh & {NUM_SLAVES{wbm_stb_i}};

    // abort_pulse is only ever set on entry to ABORT, so it lasts one cycle.
    assign wbm_dat_o = s_dat;
    assign wbm_ack_o = s_ack;
    assign wbm_err_o = s_err | abort_pulse;
    assign active    = busy;

endmodule

// File: tb/tb_wb_decoder.sv
// Self-checking bench for wb_decoder: directed cases plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_wb_decoder;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [N*AW-1:0] ADDR_V =
        {32'h0000_3000, 32'h0000_2000, 32'h0000_0000, 32'h0000_0100};
    localparam logic [N*AW-1:0] MASK_V =
        {32'h0000_F000, 32'h0000_F000, 32'h0000_F000, 32'h0000_FF00};
`ifdef WB_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          wb_clk = 1'b0;
    logic          wb_rst = 1'b1;
    logic [31:0]   wbm_adr_i = '0;
    logic [31:0]   wbm_dat_i = '0;
    logic [3:0]    wbm_sel_i = '0;
    logic          wbm_we_i = 1'b0;
    logic          wbm_cyc_i = 1'b0;
    logic          wbm_stb_i = 1'b0;
    logic [31:0]   wbm_dat_o;
    logic          wbm_ack_o;
    logic          wbm_err_o;
    logic [31:0]   wbs_adr_o;
    logic [31:0]   wbs_dat_o;
    logic [3:0]    wbs_sel_o;
    logic          wbs_we_o;
    logic [3:0]    wbs_cyc_o;
    logic [3:0]    wbs_stb_o;
    logic [127:0]  wbs_dat_i = '0;
    logic [3:0]    wbs_ack_i = '0;
    logic [3:0]    wbs_err_i = '0;
    logic          active;
    logic [1:0]    slave_sel;

    int checks = 0;
    int errors = 0;

    wb_decoder #(
        .NUM_SLAVES (N),
        .AW         (AW),
        .DW         (DW),
        .SLAVE_ADDR (ADDR_V),
        .SLAVE_MASK (MASK_V),
        .TIMEOUT    (TO)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .active    (active),
        .slave_sel (slave_sel)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & MASK_V[i*AW +: AW]) == ADDR_V[i*AW +: AW]) return i;
        end
        return -1;
    endfunction

    // Reference model: which slave owns the master cycle (-1 none), whether
    // the cycle has been refused, and how long the owner has stalled.
    int         m_route = -1;
    bit         m_abort = 1'b0;
    bit         m_pulse = 1'b0;
    int         m_wait = 0;
    logic [1:0] m_sel = '0;
    bit         model_valid = 1'b0;

    int         n_route, n_wait, k_dec;
    bit         n_abort, n_pulse, resp;
    logic [1:0] n_sel;

    always_comb begin
        n_route = m_route;
        n_abort = m_abort;
        n_pulse = 1'b0;
        n_wait  = m_wait;
        n_sel   = m_sel;
        k_dec   = decode(wbm_adr_i);
        resp    = 1'b0;
        if (m_route >= 0) resp = wbs_ack_i[m_route] | wbs_err_i[m_route];
        if (wb_rst) begin
            n_route = -1;
            n_abort = 1'b0;
            n_wait  = 0;
            n_sel   = '0;
        end else if (m_route >= 0) begin
            if (!wbm_cyc_i) begin
                n_route = -1;
                n_wait  = 0;
            end else if (TO_EN && wbm_stb_i && !resp && m_wait == TO) begin
                n_route = -1;
                n_abort = 1'b1;
                n_pulse = 1'b1;
                n_wait  = 0;
            end else begin
                n_wait = (wbm_stb_i && !resp) ? m_wait + 1 : 0;
            end
        end else if (m_abort) begin
            if (!wbm_cyc_i) n_abort = 1'b0;
        end else if (wbm_cyc_i && wbm_stb_i) begin
            if (k_dec >= 0) begin
                n_route = k_dec;
                n_sel   = 2'(k_dec);
            end else begin
                n_abort = 1'b1;
                n_pulse = 1'b1;
            end
        end
    end

    always @(posedge wb_clk) begin
        m_route <= n_route;
        m_abort <= n_abort;
        m_pulse <= n_pulse;
        m_wait  <= n_wait;
        m_sel   <= n_sel;
        if (wb_rst) model_valid <= 1'b1;
    end

    logic [3:0]  e_oh;
    logic [31:0] e_dat;
    logic        e_ack, e_err;

    always @(negedge wb_clk) begin
        if (model_valid) begin
            e_oh  = (m_route >= 0) ? (4'b0001 << m_route) : 4'b0000;
            e_dat = (m_route >= 0) ? wbs_dat_i[m_route*32 +: 32] : 32'h0;
            e_ack = (m_route >= 0) ? wbs_ack_i[m_route] : 1'b0;
            e_err = ((m_route >= 0) ? wbs_err_i[m_route] : 1'b0) | m_pulse;
            chk("wbs_cyc", 128'(wbs_cyc_o), 128'(wbm_cyc_i ? e_oh : 4'b0));
            chk("wbs_stb", 128'(wbs_stb_o), 128'(wbm_stb_i ? e_oh : 4'b0));
            chk("wbm_ack", 128'(wbm_ack_o), 128'(e_ack));
            chk("wbm_err", 128'(wbm_err_o), 128'(e_err));
            chk("wbm_dat", 128'(wbm_dat_o), 128'(e_dat));
            chk("active", 128'(active), 128'(m_route >= 0));
            chk("slave_sel", 128'(slave_sel), 128'(m_sel));
            chk("passthru",
                128'({wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o}),
                128'({wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i}));
        end
    end

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge wb_clk);
    endtask

    task automatic req(input logic [31:0] a, input logic we);
        wbm_adr_i = a;
        wbm_we_i  = we;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    task automatic idle();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
        wbs_ack_i = '0;
        wbs_err_i = '0;
    endtask

    int errs, first_err, acks;
    bit last_stb, sel_ok;
    logic [3:0] any_cyc;
    logic [31:0] r;
    int nib;

    initial begin
        wb_rst = 1'b1;
        step();
        step();
        at_neg();
        chk("rst_active", 128'(active), 128'(0));
        chk("rst_cyc", 128'(wbs_cyc_o), 128'(0));
        chk("rst_sel", 128'(slave_sel), 128'(0));
        chk("rst_err", 128'(wbm_err_o), 128'(0));
        step();
        wb_rst = 1'b0;
        step();

        // single read from slave 2
        wbs_dat_i[2*32 +: 32] = 32'hDEAD_BEEF;
        req(32'h0000_2004, 1'b0);
        at_neg();
        chk("rd_stb_c0", 128'(wbs_stb_o), 128'(0));
        step();
        wbs_ack_i = 4'b0100;
        at_neg();
        chk("rd_stb_c1", 128'(wbs_stb_o), 128'(4'b0100));
        chk("rd_ack", 128'(wbm_ack_o), 128'(1));
        chk("rd_dat", 128'(wbm_dat_o), 128'(32'hDEAD_BEEF));
        chk("rd_sel", 128'(slave_sel), 128'(2));
        step();
        idle();
        at_neg();
        chk("rd_cyc_drop", 128'(wbs_cyc_o), 128'(0));
        step();

        // unmapped access
        errs = 0;
        first_err = -1;
        any_cyc = '0;
        req(32'h0000_9000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            at_neg();
            if (wbm_err_o && first_err < 0) first_err = c;
            errs += int'(wbm_err_o);
            any_cyc |= wbs_cyc_o;
            step();
        end
        chk("miss_errs", 128'(errs), 128'(1));
        chk("miss_when", 128'(first_err), 128'(1));
        chk("miss_cyc", 128'(any_cyc), 128'(0));
        idle();
        step();
        at_neg();
        chk("miss_idle", 128'(active), 128'(0));
        step();

        // overlapping windows 0 and 1
        req(32'h0000_0100, 1'b0);
        step();
        at_neg();
        chk("ovl_sel", 128'(slave_sel), 128'(0));
        chk("ovl_stb", 128'(wbs_stb_o), 128'(4'b0001));
        step();
        idle();
        step();

        // stalled slave 3
        errs = 0;
        first_err = -1;
        last_stb = 1'b0;
        req(32'h0000_3000, 1'b0);
        for (int c = 0; c < 20; c++) begin
            at_neg();
            if (wbm_err_o && first_err < 0) first_err = c;
            errs += int'(wbm_err_o);
            last_stb = wbs_stb_o[3];
            step();
        end
        chk("to_errs", 128'(errs), 128'(TO_EN ? 1 : 0));
        chk("to_when", 128'(first_err), 128'(TO_EN ? TO + 2 : -1));
        chk("to_stall", 128'(last_stb), 128'(TO_EN ? 0 : 1));
        idle();
        step();
        step();

        // ack on the cycle the stall count reaches the limit
        req(32'h0000_3000, 1'b0);
        repeat (TO + 1) step();
        wbs_ack_i = 4'b1000;
        at_neg();
        chk("tie_ack", 128'(wbm_ack_o), 128'(1));
        chk("tie_err", 128'(wbm_err_o), 128'(0));
        step();
        wbs_ack_i = '0;
        at_neg();
        chk("tie_active", 128'(active), 128'(1));
        chk("tie_err2", 128'(wbm_err_o), 128'(0));
        step();
        idle();
        step();
        step();

        // burst of four writes to slave 3
        acks = 0;
        sel_ok = 1'b1;
        req(32'h0000_3000, 1'b1);
        step();
        wbs_ack_i = 4'b1000;
        for (int b = 0; b < 4; b++) begin
            at_neg();
            acks += int'(wbm_ack_o);
            sel_ok &= (slave_sel == 2'd3) && (wbs_stb_o == 4'b1000);
            step();
            wbm_adr_i = (b == 1) ? 32'h0000_2000 : 32'h0000_3000 + 32'(4*b+4);
            wbm_dat_i = $urandom;
        end
        idle();
        at_neg();
        chk("bst_acks", 128'(acks), 128'(4));
        chk("bst_sel", 128'(sel_ok), 128'(1));
        chk("bst_cyc_drop", 128'(wbs_cyc_o), 128'(0));
        chk("bst_active", 128'(active), 128'(1));
        step();
        at_neg();
        chk("bst_idle", 128'(active), 128'(0));
        step();

        // reset in the middle of a routed cycle
        req(32'h0000_2000, 1'b0);
        step();
        wb_rst = 1'b1;
        at_neg();
        chk("mrst_pre", 128'(active), 128'(1));
        step();
        at_neg();
        chk("mrst_stb", 128'(wbs_stb_o), 128'(0));
        chk("mrst_active", 128'(active), 128'(0));
        chk("mrst_sel", 128'(slave_sel), 128'(0));
        step();
        wb_rst = 1'b0;
        idle();
        step();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (!wbm_cyc_i) begin
                if ($urandom_range(0, 2) == 0) begin
                    r = $urandom;
                    nib = $urandom_range(0, 4);
                    if (nib == 4) nib = 9;
                    if ($urandom_range(0, 3) == 0) r[11:8] = 4'h1;
                    req({r[31:16], 4'(nib), r[11:0]}, 1'($urandom));
                end
            end else if ($urandom_range(0, 7) == 0) begin
                wbm_cyc_i = 1'b0;
                wbm_stb_i = 1'b0;
            end else begin
                wbm_stb_i = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) wbm_adr_i = $urandom;
            end
            wbm_dat_i = $urandom;
            wbm_sel_i = 4'($urandom);
            for (int s = 0; s < N; s++) begin
                wbs_ack_i[s] = ($urandom_range(0, 4) == 0);
                wbs_err_i[s] = ($urandom_range(0, 19) == 0);
                wbs_dat_i[s*32 +: 32] = $urandom;
            end
            wb_rst = ($urandom_range(0, 299) == 0);
            step();
        end
        wb_rst = 1'b0;
        idle();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_decoder.md
# wb_decoder

Single-master to multi-slave Wishbone B4 classic address decoder and router, the slave-side counterpart of the multi-master `arbiter`. The arbiter grants one master; this block sits on its output and steers that master's cycle to one of `NUM_SLAVES` slaves by address window. It returns the selected slave's `dat`/`ack`/`err` to the master. It also terminates unmapped or hung accesses with `err`.

## Interface
- `NUM_SLAVES`, 4: number of slave ports, 1..16.
- `AW`, 32: address width.
- `DW`, 32: data width; `sel` width is DW/8.
- `SLAVE_ADDR`, {NUM_SLAVES*AW} 0: per-slave base address, slave i in bits [i*AW +: AW].
- `SLAVE_MASK`, {NUM_SLAVES*AW} 0: per-slave mask, same packing. Hit when `(adr & mask) == base`.
- `TIMEOUT`, 255: cycles of unanswered `stb` before abort, 1..65535.
- `wb_clk` in 1: single clock, all logic on rising edge.
- `wb_rst` in 1: synchronous, active-high reset.
- `wbm_adr_i` in AW, `wbm_dat_i` in DW, `wbm_sel_i` in DW/8, `wbm_we_i` in 1, `wbm_cyc_i` in 1, `wbm_stb_i` in 1: master request.
- `wbm_dat_o` out DW, `wbm_ack_o` out 1, `wbm_err_o` out 1: master response.
- `wbs_adr_o` out AW, `wbs_dat_o` out DW, `wbs_sel_o` out DW/8, `wbs_we_o` out 1: broadcast to all slaves, passed through unregistered.
- `wbs_cyc_o` out NUM_SLAVES, `wbs_stb_o` out NUM_SLAVES: one-hot per-slave strobes.
- `wbs_dat_i` in NUM_SLAVES*DW, `wbs_ack_i` in NUM_SLAVES, `wbs_err_i` in NUM_SLAVES: per-slave responses.
- `active` out 1: high in BUSY.
- `slave_sel` out clog2(NUM_SLAVES), min 1: latched slave index.

## Operation
- FSM states are IDLE, BUSY and ABORT.
- IDLE:
  - When `wbm_cyc_i & wbm_stb_i`, the address is decoded by priority match; on overlap, the lowest index wins.
  - Hit: latch index into `slave_sel`, go to BUSY.
  - Miss: go to ABORT and pulse `wbm_err_o` for one cycle, in the cycle of entry to ABORT.
- BUSY:
  - `wbs_cyc_o[slave_sel] = wbm_cyc_i`; `wbs_stb_o[slave_sel] = wbm_stb_i`; all other bits are 0.
  - `wbm_ack_o`, `wbm_err_o` and `wbm_dat_o` are the selected slave's signals, combinational.
  - Selection is held for the whole cycle (block transfers). Addresses of later beats are not re-decoded.
  - `wbm_cyc_i` low: slave cyc drops the same cycle, and the FSM returns to IDLE next edge.
- ABORT:
  - All slave cyc/stb are 0 and `wbm_ack_o` is 0.
  - The FSM stays in ABORT until `wbm_cyc_i` is low, then returns to IDLE.
- Outside BUSY, `wbm_dat_o` is 0.
- Reset values: state IDLE; `slave_sel` 0; `active` 0; `wbs_cyc_o`/`wbs_stb_o` 0; `wbm_ack_o` 0; `wbm_err_o` 0; timeout counter 0.
- Reset mid-cycle: all slave strobes are low from the next edge, and any in-flight response is dropped.

## Timing
- Decode latency is one cycle. The slave sees `stb` first in the cycle after the master raises `cyc&stb`.
- A zero-wait-state slave therefore gives a minimum 2-cycle single access.
- Response path from slave to master is combinational, with no added latency.
- Miss: `wbm_err_o` is high exactly one cycle, one cycle after the request.
- Timeout counter:
  - 16 bits.
  - Increments each BUSY cycle with `wbm_stb_i` high and no `ack`/`err` from the selected slave.
  - Clears on `ack`/`err`, on `stb` low, and outside BUSY.
- Timeout fires when the counter equals `TIMEOUT`. That edge moves the FSM to ABORT with a one-cycle `wbm_err_o`.
- Slave strobes are forced low from that edge.
- Ack in the same cycle the counter reaches `TIMEOUT`: the ack wins and no abort occurs.

## Configuration
- `WB_DECODER_TIMEOUT_EN` defined: timeout counter and BUSY→ABORT path are present, as above.
- Not defined: no counter is built, `TIMEOUT` is ignored, and BUSY waits indefinitely for the slave. Decode-miss ABORT is unaffected.

## Structure
- Package `wb_decoder_pkg`:
  - State enum (IDLE, BUSY, ABORT).
  - Select-width function: clog2, min 1.
  - Timeout counter width constant (16).
- Sub-module `wb_addr_match`: combinational. Takes the address and the packed base/mask vectors, outputs `hit` and priority-encoded `idx`.
- The FSM, counter and response mux live in `wb_decoder`.

## Test plan
- Single read, NUM_SLAVES=4, slave 2 base 0x2000 mask 0xF000, adr 0x2004, slave 2 acks with 0xDEADBEEF → only `wbs_stb_o[2]` high at cycle+1; master gets ack and data 0xDEADBEEF.
- Unmapped adr 0x9000 → `wbm_err_o` high exactly one cycle; no `wbs_cyc_o` bit ever set; IDLE after cyc drops.
- Overlap: slaves 0 and 1 both match 0x0100 → `slave_sel`=0 and slave 0 is strobed.
- TIMEOUT=8, slave never acks → `wbm_err_o` pulse after 8 counted stb cycles, slave cyc low thereafter. With macro undefined, no err and the stall persists.
- Burst of 4 writes in one cyc to slave 3 with acks each cycle → 4 acks, `slave_sel` stable; `wbm_cyc_i` drop returns to IDLE next edge.
- `wb_rst` asserted mid-BUSY → all strobes and `active` are 0 next cycle, with state IDLE.
